// File: rtl/fetch_align_ctrl_pkg.sv
// rtl/fetch_align_ctrl_pkg.sv - shared encodings and helpers for the fetch align controller
package fetch_align_ctrl_pkg;

  typedef enum logic [1:0] {
    FA_RUN     = 2'd0,
    FA_WAIT    = 2'd1,
    FA_DISCARD = 2'd2
  } fa_state_t;

  localparam logic [1:0]  OPC_NONCOMP  = 2'b11;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != OPC_NONCOMP;
  endfunction

endpackage

// File: rtl/fetch_hw_buf.sv
// rtl/fetch_hw_buf.sv - halfword shift buffer, pops 0..2 from the head and appends 0..2 at the tail
module fetch_hw_buf
  import fetch_align_ctrl_pkg::*;
#(
  parameter  int BUF_HW = 4,
  localparam int CW     = $clog2(BUF_HW + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic [1:0]    push_i,
  input  logic [15:0]   push_lo_i,
  input  logic [15:0]   push_hi_i,
  input  logic [1:0]    pop_i,
  output logic [15:0]   head0_o,
  output logic [15:0]   head1_o,
  output logic [CW-1:0] count_o
);

  localparam int W = BUF_HW * 16;

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_count;
  logic [W-1:0]  w_shift;
  logic [W-1:0]  w_keep;
  logic [W-1:0]  w_ins;
  logic [W-1:0]  w_data_nxt;
  logic [CW-1:0] w_base;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_push_word;

  // Slots at or above count are kept zero so appends can simply be OR-ed in.
  always_comb begin
    w_push_word = (push_i == 2'd2) ? {push_hi_i, push_lo_i} : {16'h0, push_lo_i};
    w_base      = r_count - CW'(pop_i);
    w_shift     = r_data >> {pop_i, 4'b0000};
    w_keep      = ~({W{1'b1}} << {w_base, 4'b0000});
    w_ins       = (push_i == 2'd0) ? '0 : (W'(w_push_word) << {w_base, 4'b0000});
    w_data_nxt  = (w_shift & w_keep) | w_ins;
    w_count_nxt = w_base + CW'(push_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (clr_i) begin
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign head0_o = r_data[15:0];
  assign head1_o = r_data[31:16];
  assign count_o = r_count;

endmodule

// File: rtl/fetch_align_ctrl.sv
// rtl/fetch_align_ctrl.sv - word fetch sequencer and instruction boundary aligner for rv32imac decode
module fetch_align_ctrl
  import fetch_align_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          BUF_HW   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_ack_i,
  input  logic [31:0] fetch_data_i,
  output logic        inst_val_o,
  input  logic        inst_rdy_i,
  output logic [31:0] inst_o,
  output logic        inst_com_o,
  output logic [31:0] inst_pc_o
);

  localparam int            CW      = $clog2(BUF_HW + 1);
  localparam logic [CW-1:0] REQ_MAX = CW'(BUF_HW - 2);
  localparam logic [CW-1:0] CNT_1   = CW'(1);
  localparam logic [CW-1:0] CNT_2   = CW'(2);

  fa_state_t     r_state;
  fa_state_t     w_state_nxt;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_out_addr;
  logic [31:0]   r_pc;
  logic          r_drop_lo;
  logic [15:0]   w_h0;
  logic [15:0]   w_h1;
  logic [CW-1:0] w_count;
  logic          w_com;
  logic          w_issue;
  logic          w_take;
  logic          w_push_ok;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [15:0]   w_push_lo;

  fetch_hw_buf #(.BUF_HW(BUF_HW)) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (flush_i),
    .push_i    (w_push),
    .push_lo_i (w_push_lo),
    .push_hi_i (fetch_data_i[31:16]),
    .pop_i     (w_pop),
    .head0_o   (w_h0),
    .head1_o   (w_h1),
    .count_o   (w_count)
  );

  // A request only starts when two free slots exist, so a full word always fits.
  assign w_issue = (r_state == FA_RUN) && (w_count <= REQ_MAX) && !flush_i && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= FA_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FA_RUN:     if (w_issue) w_state_nxt = FA_WAIT;
      FA_WAIT: begin
        if (fetch_ack_i)  w_state_nxt = FA_RUN;
        else if (flush_i) w_state_nxt = FA_DISCARD;
      end
      FA_DISCARD: if (fetch_ack_i) w_state_nxt = FA_RUN;
      default:    w_state_nxt = FA_RUN;
    endcase
  end

  // A stale request keeps presenting its original address until memory answers it.
  always_comb begin
    fetch_req_o  = 1'b0;
    fetch_addr_o = r_fetch_addr;
    case (r_state)
      FA_RUN:     fetch_req_o = w_issue;
      FA_WAIT:    fetch_req_o = 1'b1;
      FA_DISCARD: begin
        fetch_req_o  = 1'b1;
        fetch_addr_o = r_out_addr;
      end
      default:    fetch_req_o = 1'b0;
    endcase
  end

  assign w_com      = is_compressed(w_h0);
  assign inst_val_o = w_com ? (w_count >= CNT_1) : (w_count >= CNT_2);
  assign inst_com_o = inst_val_o & w_com;
  assign inst_o     = !inst_val_o ? 32'h0 : (w_com ? {16'h0, w_h0} : {w_h1, w_h0});
  assign inst_pc_o  = r_pc;

  assign w_take    = inst_val_o & inst_rdy_i & ~flush_i;
  assign w_pop     = !w_take ? 2'd0 : (w_com ? 2'd1 : 2'd2);
  assign w_push_ok = (r_state == FA_WAIT) & fetch_ack_i & ~flush_i;
  assign w_push    = !w_push_ok ? 2'd0 : (r_drop_lo ? 2'd1 : 2'd2);
  assign w_push_lo = r_drop_lo ? fetch_data_i[31:16] : fetch_data_i[15:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc         <= {RESET_PC[31:1], 1'b0};
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_out_addr   <= {RESET_PC[31:2], 2'b00};
      r_drop_lo    <= RESET_PC[1];
    end else if (flush_i) begin
      r_pc         <= {flush_pc_i[31:1], 1'b0};
      r_fetch_addr <= {flush_pc_i[31:2], 2'b00};
      r_drop_lo    <= flush_pc_i[1];
    end else begin
      if (w_issue) r_out_addr <= r_fetch_addr;
      if (w_push_ok) begin
        r_fetch_addr <= r_fetch_addr + 32'd4;
        r_drop_lo    <= 1'b0;
      end
      if (w_take) r_pc <= r_pc + (w_com ? 32'd2 : 32'd4);
    end
  end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// tb/tb_fetch_align_ctrl.sv - scoreboard bench: memory image model predicts the instruction stream
module tb_fetch_align_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          NBUF   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        ack;
  logic [31:0] fdata;
  logic        inst_val;
  logic        inst_rdy;
  logic [31:0] inst;
  logic        inst_com;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_align_ctrl #(.RESET_PC(RST_PC), .BUF_HW(NBUF)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .flush_pc_i   (flush_pc),
    .fetch_req_o  (fetch_req),
    .fetch_addr_o (fetch_addr),
    .fetch_ack_i  (ack),
    .fetch_data_i (fdata),
    .inst_val_o   (inst_val),
    .inst_rdy_i   (inst_rdy),
    .inst_o       (inst),
    .inst_com_o   (inst_com),
    .inst_pc_o    (inst_pc)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic        com;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] sb_pc;
  logic [31:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          n_taken = 0;
  logic        pending;
  logic [31:0] pend_addr;
  logic        exp_addr_vld;
  logic [31:0] exp_addr;
  int          rdy_pct;
  int          ack_pct;
  int          flush_pct;

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic sb_extend(input int n);
    exp_t        e;
    logic [15:0] lo;
    for (int k = 0; k < n; k++) begin
      lo = hw_at(sb_pc);
      e.pc = sb_pc;
      if (lo[1:0] != 2'b11) begin
        e.inst = {16'h0, lo};
        e.com  = 1'b1;
        sb_pc  = sb_pc + 32'd2;
      end else begin
        e.inst = {hw_at(sb_pc + 32'd2), lo};
        e.com  = 1'b0;
        sb_pc  = sb_pc + 32'd4;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    sb_q.delete();
    sb_pc = {start[31:1], 1'b0};
    sb_extend(32);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},  {31'h0, fetch_req}, 32'h0);
    check({tag, "_addr"}, fetch_addr, {RST_PC[31:2], 2'b00});
    check({tag, "_val"},  {31'h0, inst_val}, 32'h0);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_com"},  {31'h0, inst_com}, 32'h0);
    check({tag, "_pc"},   inst_pc, RST_PC);
  endtask

  // Monitor: every accepted instruction must be the next one the memory image predicts.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst && inst_val && inst_rdy && !flush) begin
      checks++;
      n_taken++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got inst %h pc %h want no instruction", inst, inst_pc);
      end else begin
        e = sb_q.pop_front();
        if (inst !== e.inst || inst_com !== e.com || inst_pc !== e.pc) begin
          errors++;
          $display("FAIL inst got %h com %0b pc %h want %h com %0b pc %h",
                   inst, inst_com, inst_pc, e.inst, e.com, e.pc);
        end
      end
    end
  end

  // One clock of stimulus starting just after a falling edge; ends at the next falling edge.
  task automatic tick(input logic do_flush, input logic [31:0] fpc);
    inst_rdy = ($urandom_range(99) < rdy_pct);
    flush    = do_flush;
    flush_pc = fpc;
    if (do_flush) begin
      sb_restart(fpc);
      exp_addr_vld = 1'b1;
      exp_addr     = {fpc[31:2], 2'b00};
    end else if (sb_q.size() < 16) begin
      sb_extend(32);
    end
    #1;
    ack   = 1'b0;
    fdata = $urandom;
    if (pending) begin
      check("req_hold", {31'h0, fetch_req}, 32'h1);
      check("addr_hold", fetch_addr, pend_addr);
      if ($urandom_range(99) < ack_pct) begin
        ack   = 1'b1;
        fdata = mem[pend_addr[9:2]];
      end
    end
    #1;
    if (ack) begin
      pending = 1'b0;
    end else if (fetch_req && !pending) begin
      pending   = 1'b1;
      pend_addr = fetch_addr;
      if (exp_addr_vld) begin
        check("addr_after_flush", fetch_addr, exp_addr);
        exp_addr_vld = 1'b0;
      end
    end
    @(negedge clk);
    flush = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    flush        = 1'b0;
    ack          = 1'b0;
    inst_rdy     = 1'b0;
    pending      = 1'b0;
    exp_addr_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_restart(RST_PC);
  endtask

  initial begin
    int base;
    logic [31:0] fpc;
    rst = 1'b1; flush = 1'b0; flush_pc = '0; ack = 1'b0; fdata = '0; inst_rdy = 1'b0;
    pending = 1'b0; pend_addr = '0; exp_addr_vld = 1'b0; exp_addr = '0; sb_pc = '0;
    rdy_pct = 100; ack_pct = 100; flush_pct = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // two compressed instructions in one word
    mem[0] = 32'h4501_4505;
    do_reset();
    base = n_taken;
    repeat (20) tick(1'b0, 32'h0);
    check("t1_progress", (n_taken - base >= 4) ? 32'h1 : 32'h0, 32'h1);

    // single aligned 32-bit instruction
    mem[0] = 32'h0010_0513;
    do_reset();
    base = n_taken;
    repeat (20) tick(1'b0, 32'h0);
    check("t2_progress", (n_taken - base >= 4) ? 32'h1 : 32'h0, 32'h1);

    // 32-bit instruction straddling two words
    mem[0] = 32'h0513_4505;
    mem[1] = 32'h4505_0010;
    do_reset();
    base = n_taken;
    repeat (20) tick(1'b0, 32'h0);
    check("t3_progress", (n_taken - base >= 4) ? 32'h1 : 32'h0, 32'h1);

    // back-pressure: buffer fills, requests stop, then everything drains in order
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    rdy_pct = 0;
    repeat (10) tick(1'b0, 32'h0);
    check("bp_req_low", {31'h0, fetch_req}, 32'h0);
    check("bp_addr", fetch_addr, 32'h8);
    check("bp_val", {31'h0, inst_val}, 32'h1);
    base = n_taken;
    rdy_pct = 100;
    repeat (40) tick(1'b0, 32'h0);
    check("bp_progress", (n_taken - base >= 10) ? 32'h1 : 32'h0, 32'h1);

    // flush while a fetch is outstanding, target on an odd halfword
    mem[64] = 32'h0001_4505;
    do_reset();
    ack_pct = 0;
    for (int k = 0; k < 5 && !pending; k++) tick(1'b0, 32'h0);
    check("t5_pending", {31'h0, pending}, 32'h1);
    tick(1'b1, 32'h0000_0102);
    ack_pct = 100;
    base = n_taken;
    repeat (30) tick(1'b0, 32'h0);
    check("t5_progress", (n_taken - base >= 4) ? 32'h1 : 32'h0, 32'h1);

    // asynchronous reset in the middle of an outstanding fetch
    do_reset();
    rdy_pct = 0;
    repeat (3) tick(1'b0, 32'h0);
    check("ar_pending", {31'h0, pending}, 32'h1);
    check("ar_val", {31'h0, inst_val}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    pending = 1'b0;
    exp_addr_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_restart(RST_PC);
    check("ar_addr_after", fetch_addr, {RST_PC[31:2], 2'b00});
    rdy_pct = 100;
    repeat (20) tick(1'b0, 32'h0);

    // random traffic with flushes, including targets near the address wrap
    rdy_pct = 70; ack_pct = 50; flush_pct = 4;
    base = n_taken;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < flush_pct) begin
        case ($urandom_range(3))
          0, 1: fpc = {22'h0, 10'($urandom_range(1023))};
          2:    fpc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
          default: fpc = $urandom;
        endcase
        tick(1'b1, fpc);
      end else begin
        tick(1'b0, 32'h0);
      end
    end
    check("rand_progress", (n_taken - base >= 500) ? 32'h1 : 32'h0, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
